// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_pkg
// Purpose: Shared definitions for the UART receive path. It holds the receive
//          control FSM state encoding and the default frame constants.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    START_BIT_RCVD = 3'd1,
    RCV_PACKET     = 3'd2,
    STOP_BIT_RCVD  = 3'd3,
    CHK_FRAME      = 3'd4,
    STORE_DATA     = 3'd5
  } rcu_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module : rx_bit_timer
// Purpose: Bit-period timer for the UART receiver. It generates one mid-bit
//          sample strobe per frame bit (start bit excluded) and flags the
//          final (stop-bit) strobe.
// Ports  : clk          - system clock
//          n_rst        - asynchronous active-low reset
//          enable       - count while high (frame in progress)
//          clear        - restart the timer for a new frame
//          shift_strobe - one-cycle mid-bit sample pulse
//          packet_done  - high together with the last strobe of the frame
// Rev    : 1.0 - initial release
// ============================================================================
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic shift_strobe,
  output logic packet_done
);

  localparam int CNT_W = $clog2((DATA_BITS + 2) * CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  logic [31:0]      target;
  logic             hit;
  logic             last_bit;

  // clk_cnt is 0 one cycle after the start pulse is sampled, so strobe k,
  // which belongs (k+1) bit periods plus half a bit after that pulse, lands on
  // clk_cnt == (k+1)*CLKS_PER_BIT + CLKS_PER_BIT/2 - 1.
  assign target   = (32'(bit_cnt_q) + 32'd1) * 32'(CLKS_PER_BIT)
                  + 32'(CLKS_PER_BIT / 2) - 32'd1;
  assign last_bit = (bit_cnt_q == BIT_W'(DATA_BITS));
  // done_q blocks any strobe after the stop bit while the FSM drains.
  assign hit      = enable && !done_q && (32'(clk_cnt_q) == target);

  assign shift_strobe = hit;
  assign packet_done  = hit && last_bit;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = done_q;
    if (clear) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      done_d    = 1'b0;
    end else if (enable) begin
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
      if (hit) begin
        if (last_bit) begin
          done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : rx_ctrl_unit
// Purpose: UART receive control unit. It sequences one frame from start-bit
//          detection to receive-buffer load, drives the stop-bit checker and
//          hosts the bit-period timer that produces the shift strobes.
// Ports  : clk                - system clock
//          n_rst              - asynchronous active-low reset
//          start_bit_detected - one-cycle pulse from the start-bit detector
//          framing_error      - registered flag from the stop-bit checker
//          sbc_clear          - clears the stop-bit checker
//          sbc_enable         - tells the stop-bit checker to evaluate
//          shift_strobe       - sample/shift pulse for the shift register
//          load_buffer        - loads the receive buffer (good frames only)
//          rx_busy            - high whenever the FSM is not in IDLE
// Rev    : 1.0 - initial release
// ============================================================================
module rx_ctrl_unit
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic framing_error,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic shift_strobe,
  output logic load_buffer,
  output logic rx_busy
);

  rcu_state_t state_q;
  logic       sbc_clear_q;
  logic       sbc_enable_q;
  logic       load_buffer_q;
  logic       rx_busy_q;

  logic       timer_clear;
  logic       timer_enable;
  logic       packet_done;

  // The timer restarts in the same edge that accepts the start pulse, so the
  // count is 0 in the first START_BIT_RCVD cycle.
  assign timer_clear  = (state_q == IDLE) && start_bit_detected;
  assign timer_enable = (state_q != IDLE);

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (timer_enable),
    .clear        (timer_clear),
    .shift_strobe (shift_strobe),
    .packet_done  (packet_done)
  );

  // Outputs are registered alongside the state so each one is asserted in
  // exactly the cycle its state is entered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      sbc_clear_q   <= 1'b0;
      sbc_enable_q  <= 1'b0;
      load_buffer_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      sbc_clear_q   <= 1'b0;
      sbc_enable_q  <= 1'b0;
      load_buffer_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_bit_detected) begin
            state_q     <= START_BIT_RCVD;
            sbc_clear_q <= 1'b1;
            rx_busy_q   <= 1'b1;
          end
        end
        START_BIT_RCVD: begin
          state_q <= RCV_PACKET;
        end
        RCV_PACKET: begin
          if (packet_done) begin
            state_q      <= STOP_BIT_RCVD;
            sbc_enable_q <= 1'b1;
          end
        end
        STOP_BIT_RCVD: begin
          state_q <= CHK_FRAME;
        end
        CHK_FRAME: begin
          if (framing_error) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end else begin
            state_q       <= STORE_DATA;
            load_buffer_q <= 1'b1;
          end
        end
        STORE_DATA: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign sbc_clear   = sbc_clear_q;
  assign sbc_enable  = sbc_enable_q;
  assign load_buffer = load_buffer_q;
  assign rx_busy     = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_rx_ctrl_unit
// Purpose: Self-checking bench for rx_ctrl_unit. Two instances are exercised:
//          default parameters (10 clocks/bit, 8 data bits) and the minimum
//          configuration (4 clocks/bit, 5 data bits). Outputs are compared
//          every cycle against a frame-timing reference model and against
//          directed vector tables. Vector bits are {clr,en,stb,ld,busy}.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rx_ctrl_unit;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic st_a = 1'b0, fe_a = 1'b0, st_b = 1'b0, fe_b = 1'b0;
  logic clr_a, en_a, stb_a, ld_a, busy_a;
  logic clr_b, en_b, stb_b, ld_b, busy_b;

  always #5 clk = ~clk;

  rx_ctrl_unit #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .start_bit_detected(st_a), .framing_error(fe_a),
    .sbc_clear(clr_a), .sbc_enable(en_a), .shift_strobe(stb_a),
    .load_buffer(ld_a), .rx_busy(busy_a)
  );

  rx_ctrl_unit #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_bit_detected(st_b), .framing_error(fe_b),
    .sbc_clear(clr_b), .sbc_enable(en_b), .shift_strobe(stb_b),
    .load_buffer(ld_b), .rx_busy(busy_b)
  );

  typedef struct {
    int         off;
    logic       st;
    logic       fe;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_BUSY = 5'b00001;
  localparam logic [4:0] V_CLR  = 5'b10001;
  localparam logic [4:0] V_EN   = 5'b01001;
  localparam logic [4:0] V_STB  = 5'b00101;
  localparam logic [4:0] V_LD   = 5'b00011;

  vec_t       tab[$];
  logic [4:0] lastgot [2];
  int         nerr = 0;
  int         nchk = 0;
  int         cyc  = 0;

  // Reference model: a frame is described only by the cycle its start pulse
  // was accepted and whether its stop bit was bad.
  int   mf0 [2];
  logic mfe [2];

  function automatic int cpb(input int i);
    return (i == 0) ? 10 : 4;
  endfunction

  function automatic int dbits(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  // Offset of the last (stop-bit) strobe from the accepted start pulse.
  function automatic int last_strobe(input int i);
    return (dbits(i) + 1) * cpb(i) + cpb(i) / 2;
  endfunction

  function automatic bit model_busy(input int i, input int n);
    int d;
    int fin;
    if (mf0[i] < 0) return 1'b0;
    d   = n - mf0[i];
    fin = mfe[i] ? last_strobe(i) + 2 : last_strobe(i) + 3;
    return (d >= 1) && (d <= fin);
  endfunction

  function automatic logic [4:0] model_exp(input int i, input int n);
    logic [4:0] r;
    int         d;
    int         m;
    int         c;
    r = 5'b0;
    if (model_busy(i, n)) begin
      c = cpb(i);
      d = n - mf0[i];
      m = d - c / 2;
      r[0] = 1'b1;
      r[4] = (d == 1);
      r[3] = (d == last_strobe(i) + 1);
      r[1] = !mfe[i] && (d == last_strobe(i) + 3);
      r[2] = (m >= c) && (m % c == 0) && (m / c <= dbits(i) + 1);
    end
    return r;
  endfunction

  task automatic model_update(input int i, input int n, input logic s, input logic e);
    if (!model_busy(i, n)) begin
      if (s) begin
        mf0[i] = n;
        mfe[i] = 1'b0;
      end
    end else if (n - mf0[i] == last_strobe(i) + 2) begin
      mfe[i] = e;
    end
  endtask

  task automatic check_vec(input string nm, input logic [4:0] got, input logic [4:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%b expected=%b ({clr,en,stb,ld,busy})", nm, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle,
  // compare both instances against the model, then advance the model.
  task automatic tick(input logic s0, input logic e0, input logic s1, input logic e1);
    @(posedge clk);
    #1;
    st_a = s0; fe_a = e0; st_b = s1; fe_b = e1;
    @(negedge clk);
    lastgot[0] = {clr_a, en_a, stb_a, ld_a, busy_a};
    lastgot[1] = {clr_b, en_b, stb_b, ld_b, busy_b};
    check_vec("model_a", lastgot[0], model_exp(0, cyc));
    check_vec("model_b", lastgot[1], model_exp(1, cyc));
    model_update(0, cyc, s0, e0);
    model_update(1, cyc, s1, e1);
    cyc++;
  endtask

  task automatic pulse_reset(input string nm);
    st_a = 1'b0; fe_a = 1'b0; st_b = 1'b0; fe_b = 1'b0;
    n_rst = 1'b0;
    #1;
    check_vec({nm, "_a"}, {clr_a, en_a, stb_a, ld_a, busy_a}, V_IDLE);
    check_vec({nm, "_b"}, {clr_b, en_b, stb_b, ld_b, busy_b}, V_IDLE);
    mf0[0] = -1; mf0[1] = -1;
    mfe[0] = 1'b0; mfe[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Applies the current table to one instance for len cycles starting at
  // offset 0 (the start-pulse cycle) and counts strobes and loads seen.
  task automatic run_table(input int idx, input int len, input string nm,
                           output int nstb, output int nld);
    int   hit;
    logic s;
    logic e;
    nstb = 0;
    nld  = 0;
    for (int o = 0; o < len; o++) begin
      hit = -1;
      s   = 1'b0;
      e   = 1'b0;
      foreach (tab[k]) if (tab[k].off == o) hit = k;
      if (hit >= 0) begin
        s = tab[hit].st;
        e = tab[hit].fe;
      end
      if (idx == 0) tick(s, e, 1'b0, 1'b0);
      else          tick(1'b0, 1'b0, s, e);
      if (lastgot[idx][2]) nstb++;
      if (lastgot[idx][1]) nld++;
      if (hit >= 0) check_vec($sformatf("%s@%0d", nm, o), lastgot[idx], tab[hit].exp);
    end
  endtask

  task automatic fill_good(input bit spurious);
    tab.delete();
    tab.push_back('{0,  1'b1, 1'b0, V_IDLE});
    tab.push_back('{1,  1'b0, 1'b0, V_CLR});
    tab.push_back('{2,  1'b0, 1'b0, V_BUSY});
    tab.push_back('{14, 1'b0, 1'b0, V_BUSY});
    tab.push_back('{15, 1'b0, 1'b0, V_STB});
    tab.push_back('{16, 1'b0, 1'b0, V_BUSY});
    tab.push_back('{20, spurious, 1'b0, V_BUSY});
    tab.push_back('{25, 1'b0, 1'b0, V_STB});
    tab.push_back('{55, 1'b0, 1'b0, V_STB});
    tab.push_back('{95, 1'b0, 1'b0, V_STB});
    tab.push_back('{96, spurious, 1'b0, V_EN});
    tab.push_back('{97, 1'b0, 1'b0, V_BUSY});
    tab.push_back('{98, 1'b0, 1'b0, V_LD});
    tab.push_back('{99, 1'b0, 1'b0, V_IDLE});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    int nl;
    mf0[0] = -1; mf0[1] = -1;
    mfe[0] = 1'b0; mfe[1] = 1'b0;

    // Reset, then 50 quiet cycles.
    #2;
    pulse_reset("reset_hold");
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Good frame, default parameters.
    fill_good(1'b0);
    run_table(0, 100, "good", ns, nl);
    check_int("good_strobes", ns, 9);
    check_int("good_loads", nl, 1);

    // Framing error sampled in CHK_FRAME.
    tab.delete();
    tab.push_back('{0,  1'b1, 1'b0, V_IDLE});
    tab.push_back('{1,  1'b0, 1'b0, V_CLR});
    tab.push_back('{95, 1'b0, 1'b0, V_STB});
    tab.push_back('{96, 1'b0, 1'b0, V_EN});
    tab.push_back('{97, 1'b0, 1'b1, V_BUSY});
    tab.push_back('{98, 1'b0, 1'b1, V_IDLE});
    tab.push_back('{99, 1'b0, 1'b1, V_IDLE});
    run_table(0, 102, "ferr", ns, nl);
    check_int("ferr_strobes", ns, 9);
    check_int("ferr_loads", nl, 0);

    // Spurious start pulses mid-frame are ignored.
    fill_good(1'b1);
    run_table(0, 100, "spur", ns, nl);
    check_int("spur_strobes", ns, 9);
    check_int("spur_loads", nl, 1);

    // Reset mid-frame: outputs drop at once, no strobes afterwards.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 50; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_reset("reset_mid");
    ns = 0;
    nl = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (lastgot[0][2]) ns++;
      if (lastgot[0][1]) nl++;
    end
    check_int("abort_strobes", ns, 0);
    check_int("abort_loads", nl, 0);
    fill_good(1'b0);
    run_table(0, 100, "after_rst", ns, nl);
    check_int("after_rst_strobes", ns, 9);

    // Minimum configuration, back-to-back frames.
    tab.delete();
    tab.push_back('{0,  1'b1, 1'b0, V_IDLE});
    tab.push_back('{1,  1'b0, 1'b0, V_CLR});
    tab.push_back('{5,  1'b0, 1'b0, V_BUSY});
    tab.push_back('{6,  1'b0, 1'b0, V_STB});
    tab.push_back('{10, 1'b0, 1'b0, V_STB});
    tab.push_back('{14, 1'b0, 1'b0, V_STB});
    tab.push_back('{18, 1'b0, 1'b0, V_STB});
    tab.push_back('{22, 1'b0, 1'b0, V_STB});
    tab.push_back('{26, 1'b0, 1'b0, V_STB});
    tab.push_back('{27, 1'b0, 1'b0, V_EN});
    tab.push_back('{28, 1'b0, 1'b0, V_BUSY});
    tab.push_back('{29, 1'b0, 1'b0, V_LD});
    tab.push_back('{30, 1'b1, 1'b0, V_IDLE});
    tab.push_back('{31, 1'b0, 1'b0, V_CLR});
    tab.push_back('{36, 1'b0, 1'b0, V_STB});
    run_table(1, 40, "b2b", ns, nl);
    check_int("b2b_strobes", ns, 7);
    check_int("b2b_loads", nl, 1);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised starts and framing errors on both instances.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 12) == 0, 1'($urandom % 2),
           ($urandom % 8) == 0,  1'($urandom % 2));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
